latch_pipe_stage: RTL

Parametrised elastic pipeline register for the MIPS-DLX datapath. It replaces the fixed IF/ID latch and is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries PC, instruction/data word and a sideband field through a 2-entry skid buffer with a valid/ready handshake. It also provides flush-to-NOP, a debug-unit freeze input and a saturating stall counter.

---
 rtl/latch_pipe_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/latch_pipe_stage.sv
// Elastic two-entry pipeline register for the MIPS-DLX datapath: carries PC, instruction/data and
// sideband through a main/skid pair with valid/ready handshake, flush-to-NOP, freeze and stall counter.
module latch_pipe_stage #(
    parameter int NB_PC   = 32,
    parameter int NB_DATA = 32,
    parameter int NB_META = 8,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_PC-1:0]   i_pc,
    input  logic [NB_DATA-1:0] i_instruction,
    input  logic [NB_META-1:0] i_meta,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_PC-1:0]   o_pc,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_META-1:0] o_meta,
    output logic [1:0]         o_count,
    output logic [NB_CNT-1:0]  o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] value);
        logic [NB_CNT-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_PC-1:0]   r_main_pc;
    logic [NB_DATA-1:0] r_main_instruction;
    logic [NB_META-1:0] r_main_meta;
    logic [NB_PC-1:0]   r_skid_pc;
    logic [NB_DATA-1:0] r_skid_instruction;
    logic [NB_META-1:0] r_skid_meta;
    logic [NB_CNT-1:0]  r_stall_cycles;

    logic w_main_valid;
    logic w_accept;
    logic w_pop;
    logic w_stall;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // o_ready is purely a function of registered occupancy plus enable/reset, never of i_ready.
    assign w_main_valid   = (r_state != ST_EMPTY);
    assign o_ready        = i_reset & i_enable & (r_state != ST_FULL);
    assign o_valid        = i_enable & w_main_valid;
    assign w_accept       = i_valid & o_ready;
    assign w_pop          = o_valid & i_ready;
    assign w_stall        = o_valid & ~i_ready & ~i_flush;

    assign o_pc           = r_main_pc;
    assign o_instruction  = r_main_instruction;
    assign o_meta         = r_main_meta;
    assign o_count        = r_state;
    assign o_stall_cycles = r_stall_cycles;

    // Occupancy next-state and payload-routing decode.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_state_next   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                    end else begin
                        w_state_next = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_next     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end else begin
                        w_state_next = ST_FULL;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register; reset outranks flush, which is folded into the next-state decode.
    always_ff @(negedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Main entry payload; it keeps its last value when popped empty so downstream qualifies on o_valid.
    always_ff @(negedge i_clock) begin
        if (!i_reset || i_flush) begin
            r_main_pc          <= {NB_PC{1'b0}};
            r_main_instruction <= {NB_DATA{1'b0}};
            r_main_meta        <= {NB_META{1'b0}};
        end else if (w_load_main_in) begin
            r_main_pc          <= i_pc;
            r_main_instruction <= i_instruction;
            r_main_meta        <= i_meta;
        end else if (w_load_main_skid) begin
            r_main_pc          <= r_skid_pc;
            r_main_instruction <= r_skid_instruction;
            r_main_meta        <= r_skid_meta;
        end else begin
            r_main_pc          <= r_main_pc;
            r_main_instruction <= r_main_instruction;
            r_main_meta        <= r_main_meta;
        end
    end

    // Skid entry payload, filled only when a beat arrives while main is blocked.
    always_ff @(negedge i_clock) begin
        if (!i_reset || i_flush) begin
            r_skid_pc          <= {NB_PC{1'b0}};
            r_skid_instruction <= {NB_DATA{1'b0}};
            r_skid_meta        <= {NB_META{1'b0}};
        end else if (w_load_skid) begin
            r_skid_pc          <= i_pc;
            r_skid_instruction <= i_instruction;
            r_skid_meta        <= i_meta;
        end else begin
            r_skid_pc          <= r_skid_pc;
            r_skid_instruction <= r_skid_instruction;
            r_skid_meta        <= r_skid_meta;
        end
    end

    // Saturating backpressure counter, cleared only by reset.
    always_ff @(negedge i_clock) begin
        if (!i_reset) begin
            r_stall_cycles <= {NB_CNT{1'b0}};
        end else if (w_stall) begin
            r_stall_cycles <= sat_inc(r_stall_cycles);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

endmodule
